// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state enum and counter helpers for the bit-serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W = $clog2(WIDTH_DEFAULT);

  // Counter width for an arbitrary operand width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    return c + 32'd1;
  endfunction

  function automatic int last_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - FullAdder: the single 1-bit full-adder cell
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Co,
  output logic S
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer, LSB first through one FullAdder
// SERIAL_ADD_OVF_EN enables the registered signed-overflow flag OV; otherwise OV is tied to 0.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OV
);

  import serial_add_pkg::*;

  localparam int CNT_BITS = cnt_w(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(last_bit(WIDTH));

  sa_state_t state, state_nxt;

  logic [WIDTH-1:0]    a_sr;
  logic [WIDTH-1:0]    b_sr;
  logic [WIDTH-2:0]    sum_sr;
  logic [WIDTH-1:0]    sum_cat;
  logic [CNT_BITS-1:0] cnt;
  logic                carry;
  logic                cell_s;
  logic                cell_co;
  logic                accept;
  logic                last;

  FullAdder u_fa (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .Ci (carry),
    .Co (cell_co),
    .S  (cell_s)
  );

  // Newest sum bit enters at the MSB; the full word is only copied to S on the last bit.
  assign sum_cat = {cell_s, sum_sr};
  assign last    = (state == RUN) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      Co     <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
      a_sr   <= A;
      b_sr   <= B ^ {WIDTH{sub}};
      sum_sr <= '0;
      carry  <= sub;
      cnt    <= '0;
      S      <= '0;
      Co     <= 1'b0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_cat[WIDTH-1:1];
      carry  <= cell_co;
      cnt    <= CNT_BITS'(cnt_inc(32'(cnt)));
      if (last) begin
        S  <= sum_cat;
        Co <= cell_co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ov_q;

  // On the last bit, carry holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
    end else if (accept) begin
      ov_q <= 1'b0;
    end else if (last) begin
      ov_q <= carry ^ cell_co;
    end
  end

  assign OV = ov_q;
`else
  assign OV = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Co;
  logic         OV;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  exp_t exp_q[$];

  int   m_state;
  int   m_cnt;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Co    (Co),
    .OV    (OV)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t        e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    e.s  = full[W-1:0];
    e.co = full[W];
`ifdef SERIAL_ADD_OVF_EN
    e.ov = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
`else
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  // Cycle model of the sequencer: pushes the expected result at each accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      exp_q.delete();
    end else begin
      case (m_state)
        0: if (start) begin
          exp_q.push_back(model_op(A, B, sub));
          m_state <= 1;
          m_cnt   <= 0;
        end
        1: if (m_cnt == W - 1) m_state <= 2;
           else m_cnt <= m_cnt + 1;
        default: m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("busy", busy, (m_state != 0));
      check("done", done, (m_state == 2));
      if (m_state == 2) begin
        check("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("S", S, e.s);
          check("Co", Co, e.co);
          check("OV", OV, e.ov);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string ph);
    check({ph, "_busy"}, busy, 0);
    check({ph, "_done"}, done, 0);
    check({ph, "_S"}, S, 0);
    check({ph, "_Co"}, Co, 0);
    check({ph, "_OV"}, OV, 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    A = a; B = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b; sub = ~s;
    repeat (W + 2) tick();
  endtask

  logic [W-1:0] ta [6] = '{8'h3C, 8'hFF, 8'h05, 8'h07, 8'h7F, 8'h80};
  logic [W-1:0] tb [6] = '{8'h05, 8'h01, 8'h07, 8'h05, 8'h01, 8'h01};
  logic         ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    #1;
    check_zero("rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_op(ta[i], tb[i], ts[i]);

    for (int i = 0; i < 6; i++) do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    // start held high while operands change every cycle
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      A = W'($urandom); B = W'($urandom); sub = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    repeat (W + 3) tick();

    // abort mid-RUN at bit 4
    A = 8'hAA; B = 8'h55; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    tick();
    rst_n = 1'b1;
    tick();
    do_op(8'h10, 8'h20, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
